spi_multi: RTL

SPI_MULTI -- requirements
Module: spi_multi

---
 rtl/spi_multi_if.sv | 19 +
 rtl/spi_multi.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spi_multi_if.sv
// Host-side bus of the multi-channel SPI master: transfer request fields and
// completion status. The serial pins stay plain ports on spi_multi.
interface spi_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             start;
  logic [CW-1:0]    ch;
  logic             hold;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;

  modport master (output start, ch, hold, tx_data, input rx_data, busy, done);
  modport slave  (input start, ch, hold, tx_data, output rx_data, busy, done);
endinterface

// File: rtl/spi_multi.sv
// Mode-0 SPI master sharing SCK/SDO across CHANNELS chip selects, with optional
// CSX hold between words. Define SPI_MULTI_LSB_FIRST_EN to shift LSB first.
module spi_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int DIV      = 4
) (
  input  logic                clk,
  input  logic                rst,
  spi_multi_if.slave          bus,
  input  logic [CHANNELS-1:0] sdi,
  output logic                sck,
  output logic                sdo,
  output logic [CHANNELS-1:0] csx
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LD   = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW:0]   CH_LIM   = (CW + 1)'(CHANNELS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                pend_q, pend_d;
  logic                held_q, held_d;
  logic                hold_q, hold_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [WIDTH-1:0]    tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0]    rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0]    rx_data_q, rx_data_d;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                sck_q, sck_d;
  logic [CHANNELS-1:0] csx_q, csx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic             accept;
  logic             tx_bit;
  logic [WIDTH-1:0] tx_next;
  logic [WIDTH-1:0] rx_next;

`ifdef SPI_MULTI_LSB_FIRST_EN
  assign tx_bit  = tx_sh_q[0];
  assign tx_next = {1'b0, tx_sh_q[WIDTH-1:1]};
  assign rx_next = {sdi[ch_q], rx_sh_q[WIDTH-1:1]};
`else
  assign tx_bit  = tx_sh_q[WIDTH-1];
  assign tx_next = {tx_sh_q[WIDTH-2:0], 1'b0};
  assign rx_next = {rx_sh_q[WIDTH-2:0], sdi[ch_q]};
`endif

  assign accept = (state_q == S_IDLE) && !pend_q && bus.start && ({1'b0, bus.ch} < CH_LIM);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    held_d    = held_q;
    hold_d    = hold_q;
    ch_d      = ch_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sck_d     = sck_q;
    csx_d     = csx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          // one-cycle gap with every CSX high has elapsed; select the new channel
          pend_d  = 1'b0;
          csx_d   = ~(CHANNELS'(1) << ch_q);
          state_d = S_SHIFT;
          div_d   = DIV_LD;
          bit_d   = '0;
        end else if (accept) begin
          ch_d    = bus.ch;
          hold_d  = bus.hold;
          tx_sh_d = bus.tx_data;
          busy_d  = 1'b1;
          held_d  = 1'b0;
          if (held_q && (bus.ch != ch_q)) begin
            csx_d  = '1;
            pend_d = 1'b1;
          end else begin
            csx_d   = ~(CHANNELS'(1) << bus.ch);
            state_d = S_SHIFT;
            div_d   = DIV_LD;
            bit_d   = '0;
          end
        end
      end
      S_SHIFT: begin
        if (div_q == '0) begin
          div_d = DIV_LD;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_sh_d = rx_next;
          end else if (bit_q == BIT_LAST) begin
            state_d = S_FINISH;
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_sh_d = tx_next;
          end
        end else begin
          div_d = div_q - DW'(1);
        end
      end
      S_FINISH: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        rx_data_d = rx_sh_q;
        held_d    = hold_q;
        if (!hold_q) csx_d = '1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      held_q    <= 1'b0;
      hold_q    <= 1'b0;
      ch_q      <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      sck_q     <= 1'b0;
      csx_q     <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      held_q    <= held_d;
      hold_q    <= hold_d;
      ch_q      <= ch_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sck_q     <= sck_d;
      csx_q     <= csx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sck         = sck_q;
  assign sdo         = (state_q == S_SHIFT) & tx_bit;
  assign csx         = csx_q;
  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
